instr_fetch_unit: RTL

Fetch stage directly downstream of the PC register. Takes the current PC value, issues one instruction-memory read per PC, and holds the returned word for decode behind a valid/ready handshake. Drives the PC register's enable: the PC advances only when a fetch request is accepted or when a redirect occurs. Handles flush (branch/jump redirect) by discarding any in-flight response, and flags misaligned PCs.

---
 rtl/rv_fetch_pkg.sv | 23 ++
 rtl/fetch_hold_reg.sv | 39 +++
 rtl/instr_fetch_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rv_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_fetch_pkg
// Description : Shared constants and state encoding for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_fetch_pkg;

  // Byte address of instruction-memory word 0; also the PC reset vector.
  localparam logic [31:0] MEM_BASE_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] RESET_VECTOR     = 32'h0040_0000;

  // addi x0, x0, 0 -- substituted by decode when no instruction is valid.
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  // Fetch controller state encoding.
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fetch_hold_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_hold_reg
// Description : Holding register presenting one fetched instruction and its
//               PC to decode. load captures a word, clear drops valid.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_hold_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] pc
);

  // Capture on load; clear only drops valid so data and pc remain stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= data_in;
      pc    <= pc_in;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage behind the PC register. Issues one memory read
//               per PC, holds the returned word for decode, drives the PC
//               enable, discards responses made stale by a redirect and
//               flags misaligned PCs.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = ADDR_WIDTH'(MEM_BASE_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_value,
  output logic                  pc_enable,
  input  logic                  flush,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  output logic                  fetch_fault
);

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic                  discard;
  logic                  discard_next;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_offset;
  logic                  pc_aligned;
  logic                  req_accept;
  logic                  hold_load;
  logic                  hold_clear;
  logic                  fault_set;
  logic                  fault_clr;

  // Word index relative to the memory base; wraps modulo 2^ADDR_WIDTH.
  assign pc_offset      = pc_value - MEM_BASE;
  assign imem_addr      = {2'b00, pc_offset[ADDR_WIDTH-1:2]};
  assign pc_aligned     = (pc_value[1:0] == 2'b00);
  assign imem_req_valid = (state == ST_FETCH) && pc_aligned;
  assign req_accept     = imem_req_valid && imem_req_ready;
  assign pc_enable      = (req_accept && !discard_next) || flush;

  // Next-state, discard and holding-register control decode.
  always_comb begin
    state_next   = state;
    discard_next = discard;
    hold_load    = 1'b0;
    hold_clear   = 1'b0;
    fault_set    = 1'b0;
    fault_clr    = 1'b0;
    case (state)
      ST_FETCH: begin
        // A redirect in the same cycle means the misaligned PC is wrong-path,
        // so it is not allowed to raise a fault.
        if (!pc_aligned) begin
          if (!flush) begin
            state_next = ST_FAULT;
            fault_set  = 1'b1;
          end
        end else if (req_accept) begin
          state_next = ST_WAIT;
          if (flush) begin
            discard_next = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          discard_next = 1'b0;
          if (!discard && !flush) begin
            hold_load  = 1'b1;
            state_next = ST_HOLD;
          end else begin
            state_next = ST_FETCH;
          end
        end else if (flush) begin
          discard_next = 1'b1;
        end
      end
      ST_HOLD: begin
        if (instr_ready || flush) begin
          hold_clear = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FAULT: begin
        if (flush) begin
          fault_clr  = 1'b1;
          state_next = ST_FETCH;
        end
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  // Controller state, discard flag, sticky fault and request PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FETCH;
      discard     <= 1'b0;
      fetch_fault <= 1'b0;
      pc_q        <= '0;
    end else begin
      state   <= state_next;
      discard <= discard_next;
      if (fault_set) begin
        fetch_fault <= 1'b1;
      end else if (fault_clr) begin
        fetch_fault <= 1'b0;
      end
      if (req_accept) begin
        pc_q <= pc_value;
      end
    end
  end

  fetch_hold_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .load    (hold_load),
    .clear   (hold_clear),
    .data_in (imem_rsp_data),
    .pc_in   (pc_q),
    .valid   (instr_valid),
    .data    (instr_data),
    .pc      (instr_pc)
  );

endmodule
`default_nettype wire
